// File: rtl/apb_rr_requester_arbiter.sv
// Round-robin arbiter sharing one APB completer among NUM_REQ requesters.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_rr_requester_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       err_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [ADDR_W-1:0]          paddr_o,
  output logic [DATA_W-1:0]          pwdata_o,
  input  logic                       pready_i,
  input  logic [DATA_W-1:0]          prdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       last_q, sel_q, pick;
  logic                found, grant, complete, abort;
  logic                timeout_hit;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [NUM_REQ-1:0]  done_q;

  // first requester at or after last_q+1, wrapping
  always_comb begin
    int j;
    found = 1'b0;
    pick  = last_q;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  // next-state, grant strobe and completion qualifiers
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    gnt_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found && !reset) begin
          grant        = 1'b1;
          gnt_o[pick]  = 1'b1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, pointer and captured transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      sel_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q  <= pick;
        sel_q   <= pick;
        wr_q    <= req_write_i[pick];
        addr_q  <= req_addr_i[int'(pick)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata_i[int'(pick)*DATA_W +: DATA_W];
      end
    end
  end

  // completion pulse and read data return
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      if (complete || abort)
        done_q <= NUM_REQ'(1) << sel_q;
      if (complete && !wr_q)
        rdata_q <= prdata_i;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES));

  // ACCESS cycle counter, 1 on the first ACCESS cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= CW'(1);
    end else if (state_q == ST_ACCESS && !timeout_hit) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // error pulse accompanies an aborted completion
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= abort;
  end

  assign err_o = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign psel_o    = (state_q != ST_IDLE);
  assign penable_o = (state_q == ST_ACCESS);
  assign pwrite_o  = psel_o & wr_q;
  assign paddr_o   = psel_o ? addr_q : '0;
  assign pwdata_o  = (psel_o && wr_q) ? wdata_q : '0;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_apb_rr_requester_arbiter.sv
// Scoreboard bench for apb_rr_requester_arbiter with a bench-side APB memory.
// Transfer timing and grant order come from a round-robin reference model.
module tb_apb_rr_requester_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, req_write, gnt, done;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rdata, pwdata, prdata;
  logic              err, psel, penable, pwrite, pready;
  logic [AW-1:0]     paddr;

  always #5 clk = ~clk;

  apb_rr_requester_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_i(req), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata),
    .pready_i(pready), .prdata_i(prdata)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w;
  } op_t;

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w;
    int            g;
    int            dn;
    bit            err;
  } xact_t;

  op_t          opq[N][$];
  xact_t        sb[$];
  xact_t        act;
  bit           act_v;
  logic [DW-1:0] slave_mem[16];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] last_rdata;
  logic [N-1:0] exp_gnt;
  int           cyc = 0;
  int           checks = 0;
  int           fails = 0;
  int           ptr = N - 1;
  int           busy_until = 0;
  bit           rst_req;

  assign prdata = (psel && penable) ? slave_mem[paddr[3:0]] : 32'hBAD0_0BAD;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic op_t rnd_op(int wmax);
    op_t o;
    o.wr = 1'($urandom % 2);
    o.a  = AW'($urandom);
    o.d  = $urandom;
    o.w  = int'($urandom % (wmax + 1));
    return o;
  endfunction

  // drive requester lines, predict grant, schedule completer
  task automatic drive();
    int    win;
    int    p;
    op_t   o;
    xact_t x;
    reset = rst_req;
    if (reset) begin
      sb.delete();
      act_v      = 1'b0;
      busy_until = 0;
      ptr        = N - 1;
      last_rdata = '0;
    end
    for (int k = 0; k < N; k++) begin
      if (opq[k].size() > 0) begin
        req[k]                = 1'b1;
        req_write[k]          = opq[k][0].wr;
        req_addr[k*AW +: AW]  = opq[k][0].a;
        req_wdata[k*DW +: DW] = opq[k][0].d;
      end else begin
        req[k]                = 1'b0;
        req_write[k]          = 1'($urandom);
        req_addr[k*AW +: AW]  = AW'($urandom);
        req_wdata[k*DW +: DW] = $urandom;
      end
    end
    exp_gnt = '0;
    if (!reset && cyc >= busy_until && req != '0) begin
      win = -1;
      for (int i = 1; i <= N; i++) begin
        p = (ptr + i) % N;
        if (win < 0 && req[p]) win = p;
      end
      o      = opq[win].pop_front();
      x.port = win;
      x.wr   = o.wr;
      x.a    = o.a;
      x.d    = o.d;
      x.w    = o.w;
      x.g    = cyc;
      x.dn   = cyc + 3 + o.w;
      x.err  = 1'b0;
`ifdef APB_TIMEOUT_EN
      if (o.w >= TO) begin
        x.err = 1'b1;
        x.dn  = cyc + 2 + TO;
      end
`endif
      sb.push_back(x);
      act        = x;
      act_v      = 1'b1;
      busy_until = x.dn;
      ptr        = win;
      exp_gnt[win] = 1'b1;
    end
    if (act_v && cyc >= act.g + 2 && cyc < act.dn)
      pready = !act.err && (cyc == act.g + 2 + act.w);
    else
      pready = 1'($urandom % 2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit idle();
    bit e;
    e = (sb.size() == 0);
    for (int k = 0; k < N; k++)
      if (opq[k].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic run_idle(int limit);
    int i;
    i = 0;
    while (!idle() && i < limit) begin
      step();
      i++;
    end
    step();
    checks++;
    if (!idle()) begin
      fails++;
      $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  // monitor: grants, completions and bus phases against the scoreboard
  always @(negedge clk) begin
    xact_t x;
    bit    exp_done;
    if (!reset) begin
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      exp_done = (sb.size() > 0) && (sb[0].dn == cyc);
      if (exp_done) begin
        x = sb.pop_front();
        chk("done", 64'(done), 64'(1) << x.port);
        chk("err", 64'(err), 64'(x.err));
        if (!x.err) begin
          if (x.wr) ref_mem[x.a[3:0]] = x.d;
          else      last_rdata = ref_mem[x.a[3:0]];
        end
      end else begin
        chk("done_quiet", 64'(done), 64'(0));
        chk("err_quiet", 64'(err), 64'(0));
      end
      chk("rdata", 64'(rdata), 64'(last_rdata));
      if (sb.size() > 0 && sb[0].g < cyc) begin
        x = sb[0];
        chk("psel", 64'(psel), 64'(1));
        chk("penable", 64'(penable), 64'(cyc > x.g + 1));
        chk("pwrite", 64'(pwrite), 64'(x.wr));
        chk("paddr", 64'(paddr), 64'(x.a));
        chk("pwdata", 64'(pwdata), x.wr ? 64'(x.d) : 64'(0));
      end else begin
        chk("bus_idle", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
      end
      if (psel && penable && pready && pwrite)
        slave_mem[paddr[3:0]] = pwdata;
    end
  end

  initial begin
    op_t o;
    int  k;
    rst_req   = 1'b1;
    reset     = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[12] = 32'hDEAD_CAFE;
    ref_mem[12]   = 32'hDEAD_CAFE;
    repeat (3) step();
    rst_req = 1'b0;

    o = '{wr: 1'b0, a: 10'h00C, d: 32'h0, w: 0};
    opq[2].push_back(o);
    run_idle(50);

    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) begin
        o = rnd_op(0);
        opq[p].push_back(o);
      end
    run_idle(100);

    o = '{wr: 1'b1, a: 10'h3FE, d: 32'h1234_5678, w: 5};
    opq[3].push_back(o);
    run_idle(50);

    opq[1].push_back(rnd_op(1));
    run_idle(50);
    opq[0].push_back(rnd_op(1));
    opq[3].push_back(rnd_op(1));
    run_idle(50);

    o = '{wr: 1'b1, a: 10'h005, d: 32'hA5A5_0001, w: 20};
    opq[2].push_back(o);
    repeat (5) step();
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    opq[0].push_back(rnd_op(2));
    opq[2].push_back(rnd_op(2));
    run_idle(50);

    o = '{wr: 1'b0, a: 10'h021, d: 32'h0, w: 110};
    opq[1].push_back(o);
    run_idle(300);

    for (int c = 0; c < 400; c++) begin
      if ($urandom % 3 == 0) begin
        k = int'($urandom % N);
        if (opq[k].size() < 3)
          opq[k].push_back(rnd_op(($urandom % 16 == 0) ? 20 : 3));
      end
      step();
    end
    run_idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
